// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment scan decoder.
//   NUM_DIG      : number of multiplexed digits on the display
//   GLYPH_TABLE  : active-low g..a pattern for each hex value 0..F
//   frame_state_t: frame assembly FSM states
//   single_low   : true when exactly one digit enable is asserted (low)
//   low_index    : index of the asserted (low) digit enable
package sseg_pkg;

  localparam int unsigned NUM_DIG   = 4;
  localparam int unsigned DIG_W     = 2;
  localparam int unsigned NUM_GLYPH = 16;
  localparam int unsigned SEG_W     = 7;

  // Index is the nibble value; entries are active-low segments g..a.
  localparam logic [SEG_W-1:0] GLYPH_TABLE [NUM_GLYPH] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  typedef enum logic {
    COLLECT = 1'b0,
    PUBLISH = 1'b1
  } frame_state_t;

  function automatic logic single_low(input logic [NUM_DIG-1:0] en);
    int unsigned lows;
    lows = 0;
    for (int unsigned i = 0; i < NUM_DIG; i++) begin
      if (!en[i]) lows++;
    end
    return (lows == 1);
  endfunction

  function automatic logic [DIG_W-1:0] low_index(input logic [NUM_DIG-1:0] en);
    logic [DIG_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_DIG; i++) begin
      if (!en[i]) idx = i[DIG_W-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/sseg_pattern_decode.sv
// Combinational inverse of the hex glyph table.
//   pattern : active-low segments g..a
//   nibble  : decoded hex value (0 when no glyph matches)
//   hit     : high when pattern is exactly one of the 16 hex glyphs
module sseg_pattern_decode
  import sseg_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [3:0]       nibble,
  output logic             hit
);

  always_comb begin
    nibble = '0;
    hit    = 1'b0;
    for (int unsigned g = 0; g < NUM_GLYPH; g++) begin
      if (pattern == GLYPH_TABLE[g]) begin
        nibble = g[3:0];
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Recovers the hex value shown on a time-multiplexed 4-digit seven-segment
// display by watching its active-low digit enables and segment lines.
//   clk     : system clock, all state on the rising edge
//   reset_n : asynchronous active-low reset
//   an      : active-low digit enables, an[0] is the least significant digit
//   sseg    : active-low segments, sseg[7] = dp, sseg[6:0] = g..a
//   hex     : last complete frame, digit i at hex[4i+3:4i]
//   dp      : active-high decimal points of the last complete frame
//   valid   : one-cycle pulse when hex/dp are updated
//   err     : one-cycle pulse after an accepted sample that is not a hex glyph
// STABLE_CNT (2..15) is the number of consecutive identical samples needed
// before a digit is accepted.
module sseg_scan_decoder
  import sseg_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_DIG-1:0]   an,
  input  logic [7:0]           sseg,
  output logic [NUM_DIG*4-1:0] hex,
  output logic [NUM_DIG-1:0]   dp,
  output logic                 valid,
  output logic                 err
);

  // The run counter holds (edges seen with this input) - 1, so the
  // STABLE_CNT-th identical edge is the one where it still reads STABLE_CNT-2.
  localparam logic [3:0] ACCEPT_AT = 4'(STABLE_CNT - 2);

  logic [NUM_DIG+7:0]   samp_q;
  logic [3:0]           run_q;
  logic [NUM_DIG*4-1:0] shadow_q;
  logic [NUM_DIG-1:0]   shadow_dp_q;
  logic [NUM_DIG-1:0]   seen_q;
  logic [NUM_DIG-1:0]   seen_d;
  frame_state_t         state_q;
  frame_state_t         state_d;

  logic [NUM_DIG+7:0]   cur;
  logic                 same;
  logic                 an_ok;
  logic                 accept;
  logic                 acc_good;
  logic                 acc_bad;
  logic                 publish;
  logic [DIG_W-1:0]     digit_idx;
  logic [3:0]           nibble;
  logic                 hit;

  assign cur       = {an, sseg};
  assign same      = (cur == samp_q);
  assign an_ok     = single_low(an);
  assign digit_idx = low_index(an);

  // Counter saturates above ACCEPT_AT, so a long stable run is accepted once.
  assign accept   = an_ok && same && (run_q == ACCEPT_AT);
  assign acc_good = accept && hit;
  assign acc_bad  = accept && !hit;

  sseg_pattern_decode u_decode (
    .pattern (sseg[SEG_W-1:0]),
    .nibble  (nibble),
    .hit     (hit)
  );

  // Input sampling and stability run
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      samp_q <= '1;
      run_q  <= '0;
    end else begin
      samp_q <= cur;
      if (!an_ok || !same) begin
        run_q <= '0;
      end else if (run_q != '1) begin
        run_q <= run_q + 4'd1;
      end
    end
  end

  // Shadow frame capture; a re-captured digit overwrites its entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q    <= '0;
      shadow_dp_q <= '0;
    end else if (acc_good) begin
      for (int unsigned i = 0; i < NUM_DIG; i++) begin
        if (digit_idx == i[DIG_W-1:0]) begin
          shadow_q[4*i +: 4] <= nibble;
          shadow_dp_q[i]     <= ~sseg[7];
        end
      end
    end
  end

  // Seen mask: a clear from publish or a bad glyph is applied first so that
  // a good acceptance on the same edge still marks its own digit.
  always_comb begin
    seen_d = seen_q;
    if (publish || acc_bad) begin
      seen_d = '0;
    end
    if (acc_good) begin
      seen_d[digit_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seen_q <= '0;
    end else begin
      seen_q <= seen_d;
    end
  end

  // Frame FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    publish = 1'b0;
    case (state_q)
      COLLECT: begin
        if (&seen_q) state_d = PUBLISH;
      end
      PUBLISH: begin
        publish = 1'b1;
        state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex   <= '0;
      dp    <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      valid <= publish;
      err   <= acc_bad;
      if (publish) begin
        hex <= shadow_q;
        dp  <= shadow_dp_q;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Self-checking bench for sseg_scan_decoder: table-driven scans plus hand
// sequences, with expected valid/err events queued by a reference model.
module tb_sseg_scan_decoder;

  localparam int unsigned SC = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic [15:0] hex;
  logic [3:0]  dp;
  logic        valid;
  logic        err;

  sseg_scan_decoder #(.STABLE_CNT(SC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .an      (an),
    .sseg    (sseg),
    .hex     (hex),
    .dp      (dp),
    .valid   (valid),
    .err     (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum {EV_VALID, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [15:0] hex;
    logic [3:0]  dp;
    int          cyc;
  } ev_t;

  typedef struct {
    string       name;
    logic [31:0] segs;   // digit3..digit0, one byte each
    logic [15:0] holds;  // digit3..digit0 hold cycles, 0 = digit skipped
    logic [15:0] exp_hex;
    logic [3:0]  exp_dp;
  } vec_t;

  localparam logic [6:0] REF_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  ev_t        sb[$];
  int         tests = 0;
  int         fails = 0;
  logic [3:0] m_shadow [4];
  logic [3:0] m_dpsh;
  logic [3:0] m_seen;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_shadow[i] = '0;
    m_dpsh = '0;
    m_seen = '0;
    sb.delete();
  endtask

  // Reference behaviour of one accepted sample at cycle 'at'.
  task automatic model_accept(input int i, input logic [7:0] s, input int at);
    logic       found;
    logic [3:0] nib;
    ev_t        e;
    found = 1'b0;
    nib   = '0;
    for (int g = 0; g < 16; g++) begin
      if (s[6:0] == REF_GLYPH[g]) begin
        found = 1'b1;
        nib   = 4'(g);
      end
    end
    if (found) begin
      m_shadow[i] = nib;
      m_dpsh[i]   = ~s[7];
      m_seen[i]   = 1'b1;
      if (m_seen == 4'hF) begin
        e.kind = EV_VALID;
        e.hex  = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
        e.dp   = m_dpsh;
        e.cyc  = at + 2;
        sb.push_back(e);
        m_seen = '0;
      end
    end else begin
      e.kind = EV_ERR;
      e.hex  = '0;
      e.dp   = '0;
      e.cyc  = at;
      sb.push_back(e);
      m_seen = '0;
    end
  endtask

  // Show one digit for n cycles (called at a falling edge).
  task automatic digit(input int i, input logic [7:0] s, input int n);
    logic [3:0] one;
    one = 4'b0001;
    if (n == 0) return;
    an   = ~(one << i);
    sseg = s;
    if (n >= SC) model_accept(i, s, cyc + SC);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_event(input ev_kind_t k);
    ev_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got %s at cycle %0d, required none", k.name(), cyc);
      return;
    end
    e = sb.pop_front();
    if (e.kind != k || e.cyc != cyc) begin
      fails++;
      $display("FAIL event_timing: got %s at cycle %0d, required %s at cycle %0d",
               k.name(), cyc, e.kind.name(), e.cyc);
    end
    if (k == EV_VALID && e.kind == EV_VALID) begin
      tests++;
      if (hex !== e.hex || dp !== e.dp) begin
        fails++;
        $display("FAIL frame_data: got hex=%h dp=%b, required hex=%h dp=%b",
                 hex, dp, e.hex, e.dp);
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (valid === 1'b1) check_event(EV_VALID);
        if (err === 1'b1)   check_event(EV_ERR);
      end
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_pending: got %0d events outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_out(input string name, input logic [15:0] eh, input logic [3:0] ed);
    tests++;
    if (hex !== eh || dp !== ed) begin
      fails++;
      $display("FAIL %s_out: got hex=%h dp=%b, required hex=%h dp=%b", name, hex, dp, eh, ed);
    end
  endtask

  vec_t        vecs [11];
  logic [31:0] segs;
  logic [15:0] holds;

  initial begin : main
    vecs[0]  = '{"scan_1234",   32'hF9A4B099, 16'h8888, 16'h1234, 4'b0000};
    vecs[1]  = '{"short_d2",    32'hF9A4B099, 16'h8388, 16'h1234, 4'b0000};
    vecs[2]  = '{"rescan",      32'hF9A4B099, 16'h8888, 16'h1234, 4'b0000};
    vecs[3]  = '{"blank_d1",    32'h0000FF00, 16'h00F0, 16'h1234, 4'b0000};
    vecs[4]  = '{"bad_glyph",   32'h000000F7, 16'h000F, 16'h1234, 4'b0000};
    vecs[5]  = '{"dp_scan_a",   32'hF979B099, 16'h8888, 16'h1134, 4'b0100};
    vecs[6]  = '{"dp_scan_b",   32'hF979B099, 16'h8888, 16'h1134, 4'b0100};
    vecs[7]  = '{"glyph_5678",  32'h9282F800, 16'h8888, 16'h5678, 4'b0001};
    vecs[8]  = '{"glyph_9abc",  32'h108883C6, 16'h8888, 16'h9ABC, 4'b1000};
    vecs[9]  = '{"glyph_def0",  32'hA1868EC0, 16'h8888, 16'hDEF0, 4'b0000};
    vecs[10] = '{"min_hold",    32'hF9A4B099, 16'h4444, 16'h1234, 4'b0000};

    model_reset();
    reset_n = 1'b0;
    an      = 4'hF;
    sseg    = 8'hFF;
    repeat (3) @(negedge clk);
    tests++;
    if (hex !== 16'h0 || dp !== 4'h0 || valid !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got hex=%h dp=%b valid=%b err=%b, required 0000/0000/0/0",
               hex, dp, valid, err);
    end
    reset_n = 1'b1;
    @(negedge clk);
    fork
      monitor();
    join_none

    for (int v = 0; v < 11; v++) begin
      segs  = vecs[v].segs;
      holds = vecs[v].holds;
      for (int i = 0; i < 4; i++) begin
        digit(i, segs[8*i +: 8], int'(holds[4*i +: 4]));
      end
      drain(vecs[v].name);
      check_out(vecs[v].name, vecs[v].exp_hex, vecs[v].exp_dp);
    end

    // Digits arriving out of order
    digit(3, 8'h92, 8);
    digit(1, 8'h88, 8);
    digit(0, 8'hC0, 8);
    digit(2, 8'h00, 6);
    drain("out_of_order");
    check_out("out_of_order", 16'h58A0, 4'b0100);

    // Two enables low: nothing may be accepted
    an   = 4'b1100;
    sseg = 8'h99;
    repeat (20) @(negedge clk);
    drain("two_low");
    check_out("two_low", 16'h58A0, 4'b0100);

    // Reset in the middle of a frame
    digit(1, 8'hB0, 8);
    digit(2, 8'hA4, 8);
    digit(3, 8'hF9, 8);
    #2;
    reset_n = 1'b0;
    an      = 4'hF;
    #1;
    tests++;
    if (hex !== 16'h0 || dp !== 4'h0 || valid !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got hex=%h dp=%b valid=%b err=%b, required 0000/0000/0/0",
               hex, dp, valid, err);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    digit(0, 8'h99, 8);
    digit(1, 8'hB0, 8);
    digit(2, 8'hA4, 8);
    drain("post_reset_partial");
    check_out("post_reset_partial", 16'h0000, 4'b0000);
    digit(3, 8'hF9, 8);
    drain("post_reset_full");
    check_out("post_reset_full", 16'h1234, 4'b0000);

    an   = 4'hF;
    sseg = 8'hFF;
    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sseg_scan_decoder.md
SSEG_SCAN_DECODER -- requirements
Module: sseg_scan_decoder

Interface
REQ-001 The block SHALL have parameter STABLE_CNT, default 4, giving the consecutive identical samples (2..15) required to accept a digit.
REQ-002 Port clk, input, 1 bit, is the single system clock; all state SHALL be on its rising edge.
REQ-003 Port reset_n, input, 1 bit, is an asynchronous active-low reset.
REQ-004 Port an, input, 4 bits, is the active-low digit enables of a time-multiplexed 4-digit display; an[0] is the least significant digit.
REQ-005 Port sseg, input, 8 bits, is the active-low segments; sseg[7] is dp and sseg[6:0] is g..a.
REQ-006 Port hex, output, 16 bits, is the last complete decoded frame; digit i occupies hex[4i+3:4i].
REQ-007 Port dp, output, 4 bits, is the active-high decimal-point state per digit for the last complete frame.
REQ-008 Port valid, output, 1 bit, is a one-cycle pulse marking an update of hex and dp.
REQ-009 Port err, output, 1 bit, is a one-cycle pulse marking an accepted sample whose segment pattern is not a hex glyph.

Function
REQ-010 The block SHALL register {an, sseg} every cycle into a sample register.
REQ-011 A run counter SHALL increment, saturating, while the new input equals the sample register, and SHALL clear on any difference.
REQ-012 A sample is "qualified" when an has exactly one bit low and the input has been identical for STABLE_CNT consecutive edges.
- Acceptance occurs on the STABLE_CNT-th edge.
- A qualified sample SHALL be accepted once per run; further stable cycles are not re-accepted.
REQ-013 When an is all ones, or has two or more bits low, the run counter SHALL clear and nothing SHALL be accepted.
REQ-014 Decode SHALL be the exact inverse of the hex glyph table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Any other 7-bit pattern, including blank 1111111, SHALL be invalid.
REQ-015 On accepting a valid pattern for digit i:
- write the nibble into shadow[i] and ~sseg[7] into shadow_dp[i];
- set seen[i].
- A re-captured digit SHALL overwrite its shadow entry.
REQ-016 On accepting an invalid pattern, err SHALL pulse on the following cycle, seen SHALL clear to 0000, and hex/dp SHALL be unchanged.
REQ-017 The frame FSM SHALL have two states, COLLECT and PUBLISH:
- COLLECT to PUBLISH when seen becomes 1111.
- PUBLISH SHALL load hex/dp from shadow, pulse valid for exactly one cycle, clear seen, and return to COLLECT.
REQ-018 Latency SHALL be exactly 2 cycles from the acceptance edge of the final digit to valid high, with hex and dp updated in the same cycle as valid.
REQ-019 Input accepted while in PUBLISH SHALL be captured normally into the next frame.
- An acceptance coinciding with the clear of seen SHALL take precedence for its own bit.
REQ-020 Digits MAY arrive in any order; frame completion depends only on all four seen bits being set.

Reset
REQ-021 Asserting reset_n low SHALL asynchronously clear the following: hex=0000, dp=0000, valid=0, err=0, seen=0000, the run counter, the shadow registers, and the sample register (set to all ones); the FSM SHALL go to COLLECT.
REQ-022 Reset mid-frame SHALL discard the partial frame; no valid SHALL occur until four new digits are accepted after release.

Structure
REQ-023 Package sseg_pkg SHALL hold the 16-entry glyph table constant, NUM_DIG=4, and the FSM state enum.
REQ-024 A combinational sub-module sseg_pattern_decode (7-bit pattern in; 4-bit nibble and hit flag out) SHALL implement REQ-014, and sseg_scan_decoder SHALL instantiate it once.
REQ-025 The RTL SHALL be synthesizable with no latches and no inferred memory.

Verification
REQ-026 Scan an=1110/1101/1011/0111 with sseg=99/B0/A4/F9, 8 cycles each, STABLE_CNT=4 -> hex=1234, dp=0000, valid pulses once, 2 cycles after the last acceptance.
REQ-027 Same scan, but digit 2 held only 3 cycles -> no valid. The next full scan -> hex=1234.
REQ-028 Digit 1 sseg=FF (blank) for 8 cycles -> err pulses once, no valid, and the prior hex is retained.
REQ-029 Two scans as REQ-026 with digit 2 sseg=79 (dp on, glyph 1) -> hex=1134, dp=0100, with valid for each frame.
REQ-030 an=1100 held 20 cycles -> no acceptance, no err, no valid.
REQ-031 reset_n pulsed low after 3 digits accepted -> outputs zero immediately, and a full scan is then required before valid.
